// File: rtl/life_pkg.sv
// Shared constants and helpers for the Game of Life array.
package life_pkg;

    // Live-neighbour counts that produce a live cell in the next generation.
    localparam int unsigned BIRTH_COUNT   = 3;
    localparam int unsigned SURVIVE_COUNT = 2;

    // Eight neighbours need four bits to count.
    localparam int unsigned NBR_CNT_W = 4;

    // Number of select bits needed to address `value` items (never less than one).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((64'd1 << width) < 64'(value)) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/life_cell.sv
// One Game of Life cell: current and previous-generation state, rule evaluation.
module life_cell
    import life_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic       load_val_i,
    input  logic       step_i,
    input  logic [7:0] nbr_i,
    output logic       cur_o,
    output logic       prev_o,
    output logic       change_o
);

    logic                 cur_q;
    logic                 prev_q;
    logic [NBR_CNT_W-1:0] cnt;
    logic                 nxt;

    // Count live neighbours and apply the birth/survive rule.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + NBR_CNT_W'(nbr_i[i]);
        end
        nxt = (cnt == NBR_CNT_W'(BIRTH_COUNT)) |
              (cur_q & (cnt == NBR_CNT_W'(SURVIVE_COUNT)));
    end

    // State update: load overrides step; a load also seeds the previous generation.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q  <= 1'b0;
            prev_q <= 1'b0;
        end else if (load_i) begin
            cur_q  <= load_val_i;
            prev_q <= load_val_i;
        end else if (step_i) begin
            prev_q <= cur_q;
            cur_q  <= nxt;
        end
    end

    assign cur_o    = cur_q;
    assign prev_o   = prev_q;
    assign change_o = nxt ^ cur_q;

endmodule

// File: rtl/life_array_param.sv
// Parametrised ROWS x COLS Game of Life array with torus or edge-fed boundary,
// row load/readback, generation counter and stable/extinct status.
module life_array_param
    import life_pkg::*;
#(
    parameter int unsigned ROWS  = 16,
    parameter int unsigned COLS  = 16,
    parameter int unsigned WRAP  = 0,
    parameter int unsigned GEN_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [COLS-1:0]          vali,
    input  logic [clog2(ROWS)-1:0]   vali_selector,
    input  logic                     write_enb,
    input  logic [clog2(ROWS)-1:0]   valo_selector,
    output logic [COLS-1:0]          valo,
    output logic [COLS-1:0]          valo_prev,
    input  logic                     step,
    output logic                     step_ack,
    input  logic [COLS-1:0]          ni,
    input  logic [COLS-1:0]          si,
    input  logic [ROWS-1:0]          wi,
    input  logic [ROWS-1:0]          ei,
    input  logic                     nwi,
    input  logic                     nei,
    input  logic                     sei,
    input  logic                     swi,
    output logic [COLS-1:0]          no,
    output logic [COLS-1:0]          so,
    output logic [ROWS-1:0]          wo,
    output logic [ROWS-1:0]          eo,
    output logic                     nwo,
    output logic                     neo,
    output logic                     seo,
    output logic                     swo,
    output logic [GEN_W-1:0]         gen_count,
    output logic                     stable,
    output logic                     extinct
);

    localparam int unsigned SEL_W = clog2(ROWS);
    localparam bit          TORUS = (WRAP != 0);

    logic [COLS-1:0] cur  [ROWS];
    logic [COLS-1:0] prev [ROWS];
    logic [COLS-1:0] chg  [ROWS];

    // Array surrounded by a one-cell halo; ext[r+1][c+1] is cell (r,c).
    logic [COLS+1:0] ext [ROWS+2];

    logic             step_acc;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic             ack_q, ack_d;
    logic             stable_q, stable_d;
    logic             any_chg;

    // A write on the same cycle as a step takes priority and drops the step.
    assign step_acc = step & ~write_enb;

    // Halo: wrapped copies of the opposite edge, or the external edge/diagonal inputs.
    always_comb begin
        for (int r = 0; r < ROWS + 2; r++) begin
            ext[r] = '0;
        end
        for (int r = 0; r < ROWS; r++) begin
            ext[r+1][COLS:1]    = cur[r];
            ext[r+1][0]         = TORUS ? cur[r][COLS-1] : wi[r];
            ext[r+1][COLS+1]    = TORUS ? cur[r][0]      : ei[r];
        end
        ext[0][COLS:1]           = TORUS ? cur[ROWS-1]         : ni;
        ext[ROWS+1][COLS:1]      = TORUS ? cur[0]              : si;
        ext[0][0]                = TORUS ? cur[ROWS-1][COLS-1] : nwi;
        ext[0][COLS+1]           = TORUS ? cur[ROWS-1][0]      : nei;
        ext[ROWS+1][COLS+1]      = TORUS ? cur[0][0]           : sei;
        ext[ROWS+1][0]           = TORUS ? cur[0][COLS-1]      : swi;
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic row_load;
        assign row_load = write_enb && (vali_selector == SEL_W'(r));

        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [7:0] nbr;
            assign nbr = {ext[r][c],   ext[r][c+1],   ext[r][c+2],
                          ext[r+1][c],                ext[r+1][c+2],
                          ext[r+2][c], ext[r+2][c+1], ext[r+2][c+2]};

            life_cell u_cell (
                .clk        (clk),
                .reset      (reset),
                .load_i     (row_load),
                .load_val_i (vali[c]),
                .step_i     (step_acc),
                .nbr_i      (nbr),
                .cur_o      (cur[r][c]),
                .prev_o     (prev[r][c]),
                .change_o   (chg[r][c])
            );
        end
    end

    // Row readback mux plus array-wide change and liveness reductions.
    always_comb begin
        valo      = '0;
        valo_prev = '0;
        any_chg   = 1'b0;
        extinct   = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            if (valo_selector == SEL_W'(r)) begin
                valo      = cur[r];
                valo_prev = prev[r];
            end
            any_chg = any_chg | (|chg[r]);
            extinct = extinct & ~(|cur[r]);
        end
    end

    // Edge and corner state for tiling into neighbouring arrays.
    always_comb begin
        wo = '0;
        eo = '0;
        for (int r = 0; r < ROWS; r++) begin
            wo[r] = cur[r][0];
            eo[r] = cur[r][COLS-1];
        end
    end

    assign no  = cur[0];
    assign so  = cur[ROWS-1];
    assign nwo = cur[0][0];
    assign neo = cur[0][COLS-1];
    assign seo = cur[ROWS-1][COLS-1];
    assign swo = cur[ROWS-1][0];

    // Next-state for counter, acknowledge and stable flag.
    always_comb begin
        gen_d    = gen_q;
        ack_d    = step_acc;
        stable_d = stable_q;
        if (write_enb) begin
            stable_d = 1'b0;
        end else if (step_acc) begin
            gen_d    = gen_q + GEN_W'(1);
            stable_d = ~any_chg;
        end
    end

    // Status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            gen_q    <= '0;
            ack_q    <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            gen_q    <= gen_d;
            ack_q    <= ack_d;
            stable_q <= stable_d;
        end
    end

    assign gen_count = gen_q;
    assign step_ack  = ack_q;
    assign stable    = stable_q;

endmodule

// File: tb/tb_life_array_param.sv
// Directed bench: three 8x8 arrays (edge-fed, torus, 4-bit counter) driven in lockstep.
module tb_life_array_param;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] vali, ni, si, wi, ei;
    logic [2:0] vali_selector, valo_selector;
    logic       write_enb, step, nwi, nei, sei, swi;

    logic [7:0]  valo_a, valo_prev_a, no_a, so_a, wo_a, eo_a;
    logic [7:0]  valo_t, valo_prev_t, no_t, so_t, wo_t, eo_t;
    logic [7:0]  valo_g, valo_prev_g, no_g, so_g, wo_g, eo_g;
    logic        ack_a, ack_t, ack_g, stable_a, stable_t, stable_g;
    logic        ext_a, ext_t, ext_g;
    logic        nwo_a, neo_a, seo_a, swo_a, nwo_t, neo_t, seo_t, swo_t;
    logic        nwo_g, neo_g, seo_g, swo_g;
    logic [15:0] gen_a, gen_t;
    logic [3:0]  gen_g;

    always #5 clk = ~clk;

    life_array_param #(.ROWS(8), .COLS(8), .WRAP(0), .GEN_W(16)) dut (
        .clk(clk), .reset(reset), .vali(vali), .vali_selector(vali_selector),
        .write_enb(write_enb), .valo_selector(valo_selector), .valo(valo_a),
        .valo_prev(valo_prev_a), .step(step), .step_ack(ack_a), .ni(ni), .si(si),
        .wi(wi), .ei(ei), .nwi(nwi), .nei(nei), .sei(sei), .swi(swi), .no(no_a),
        .so(so_a), .wo(wo_a), .eo(eo_a), .nwo(nwo_a), .neo(neo_a), .seo(seo_a),
        .swo(swo_a), .gen_count(gen_a), .stable(stable_a), .extinct(ext_a)
    );

    life_array_param #(.ROWS(8), .COLS(8), .WRAP(1), .GEN_W(16)) dut_t (
        .clk(clk), .reset(reset), .vali(vali), .vali_selector(vali_selector),
        .write_enb(write_enb), .valo_selector(valo_selector), .valo(valo_t),
        .valo_prev(valo_prev_t), .step(step), .step_ack(ack_t), .ni(ni), .si(si),
        .wi(wi), .ei(ei), .nwi(nwi), .nei(nei), .sei(sei), .swi(swi), .no(no_t),
        .so(so_t), .wo(wo_t), .eo(eo_t), .nwo(nwo_t), .neo(neo_t), .seo(seo_t),
        .swo(swo_t), .gen_count(gen_t), .stable(stable_t), .extinct(ext_t)
    );

    life_array_param #(.ROWS(8), .COLS(8), .WRAP(0), .GEN_W(4)) dut_g (
        .clk(clk), .reset(reset), .vali(vali), .vali_selector(vali_selector),
        .write_enb(write_enb), .valo_selector(valo_selector), .valo(valo_g),
        .valo_prev(valo_prev_g), .step(step), .step_ack(ack_g), .ni(ni), .si(si),
        .wi(wi), .ei(ei), .nwi(nwi), .nei(nei), .sei(sei), .swi(swi), .no(no_g),
        .so(so_g), .wo(wo_g), .eo(eo_g), .nwo(nwo_g), .neo(neo_g), .seo(seo_g),
        .swo(swo_g), .gen_count(gen_g), .stable(stable_g), .extinct(ext_g)
    );

    int total = 0;
    int bad   = 0;

    string       tag_q [$];
    logic [63:0] exp_q [$];

    function automatic void push(input string t, input logic [63:0] e);
        tag_q.push_back(t);
        exp_q.push_back(e);
    endfunction

    task automatic chk(input logic [63:0] obs);
        string       t;
        logic [63:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_underflow: observed=%0h expected=none", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: observed=%0h expected=%0h", t, obs, e);
            end
        end
    endtask

    function automatic logic [63:0] row(input int r, input logic [7:0] v);
        return 64'(v) << (r * 8);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int r, input logic [7:0] v);
        vali          = v;
        vali_selector = 3'(r);
        write_enb     = 1'b1;
        tick();
        write_enb     = 1'b0;
    endtask

    task automatic read_grid(output logic [63:0] pa, output logic [63:0] pt);
        pa = '0;
        pt = '0;
        for (int r = 0; r < 8; r++) begin
            valo_selector = 3'(r);
            #1;
            pa[r*8 +: 8] = valo_a;
            pt[r*8 +: 8] = valo_t;
        end
    endtask

    task automatic load_glider();
        wr(1, 8'h02);
        wr(2, 8'h04);
        wr(3, 8'h07);
    endtask

    logic [63:0] ga, gt, blinker, block, glider;

    initial begin
        reset = 1'b1; vali = '0; ni = '0; si = '0; wi = '0; ei = '0;
        vali_selector = '0; valo_selector = '0; write_enb = 1'b0; step = 1'b0;
        nwi = 1'b0; nei = 1'b0; sei = 1'b0; swi = 1'b0;
        blinker = row(3, 8'h08) | row(4, 8'h08) | row(5, 8'h08);
        block   = row(2, 8'h0C) | row(3, 8'h0C);
        glider  = row(1, 8'h02) | row(2, 8'h04) | row(3, 8'h07);

        // Reset state
        push("rst_grid", 64'h0); push("rst_gen", 64'h0); push("rst_ack", 64'h0);
        push("rst_stable", 64'h0); push("rst_extinct", 64'h1);
        tick(); tick();
        reset = 1'b0;
        read_grid(ga, gt);
        chk(ga); chk(64'(gen_a)); chk(64'(ack_a)); chk(64'(stable_a)); chk(64'(ext_a));

        // Blinker oscillates with period 2
        wr(3, 8'h08); wr(4, 8'h08); wr(5, 8'h08);
        push("blk1_ack", 64'h1); push("blk1_grid", row(4, 8'h1C));
        push("blk1_prev3", 64'h08); push("blk1_gen", 64'h1);
        step = 1'b1; tick(); step = 1'b0;
        chk(64'(ack_a));
        read_grid(ga, gt);
        chk(ga);
        valo_selector = 3'd3; #1;
        chk(64'(valo_prev_a));
        chk(64'(gen_a));
        push("blk1_ack_low", 64'h0);
        tick();
        chk(64'(ack_a));
        push("blk2_grid", blinker); push("blk2_gen", 64'h2); push("blk2_stable", 64'h0);
        step = 1'b1; tick(); step = 1'b0;
        read_grid(ga, gt);
        chk(ga); chk(64'(gen_a)); chk(64'(stable_a));

        // Still life: block is unchanged and flags stable
        wr(3, 8'h00); wr(4, 8'h00); wr(5, 8'h00);
        wr(2, 8'h0C); wr(3, 8'h0C);
        push("blk_grid", block); push("blk_stable", 64'h1); push("blk_ack", 64'h1);
        push("blk_gen", 64'h3);
        step = 1'b1; tick(); step = 1'b0;
        read_grid(ga, gt);
        chk(ga); chk(64'(stable_a)); chk(64'(ack_a)); chk(64'(gen_a));
        push("blk_ack_once", 64'h0); push("blk_stable_hold", 64'h1);
        tick();
        chk(64'(ack_a)); chk(64'(stable_a));

        // Write and step together: write wins
        push("col_grid", block | row(0, 8'h81)); push("col_ack", 64'h0);
        push("col_gen", 64'h3); push("col_stable", 64'h0);
        vali = 8'h81; vali_selector = 3'd0; write_enb = 1'b1; step = 1'b1;
        tick();
        write_enb = 1'b0; step = 1'b0;
        read_grid(ga, gt);
        chk(ga); chk(64'(ack_a)); chk(64'(gen_a)); chk(64'(stable_a));
        wr(0, 8'h00); wr(2, 8'h00); wr(3, 8'h00);

        // Edge feed: births from ni in the edge-fed array only
        ni = 8'h1C;
        push("edge_grid", row(0, 8'h08)); push("edge_no", 64'h08);
        push("edge_torus", 64'h0); push("edge_ext", 64'h0); push("edge_ext_t", 64'h1);
        step = 1'b1; tick(); step = 1'b0;
        ni = 8'h00;
        read_grid(ga, gt);
        chk(ga); chk(64'(no_a)); chk(gt); chk(64'(ext_a)); chk(64'(ext_t));
        wr(0, 8'h00);

        // Reset mid-run wins over a pending step
        load_glider();
        step = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        push("mid_grid", 64'h0); push("mid_gen", 64'h0); push("mid_extinct", 64'h1);
        push("mid_stable", 64'h0); push("mid_ack", 64'h0); push("mid_gen_g", 64'h0);
        tick();
        reset = 1'b0; step = 1'b0;
        read_grid(ga, gt);
        chk(ga); chk(64'(gen_a)); chk(64'(ext_a)); chk(64'(stable_a)); chk(64'(ack_a));
        chk(64'(gen_g));

        // Torus: glider returns after 32 generations; 4-bit counter wraps
        load_glider();
        push("hold_ack", 64'h1); push("gen4_15", 64'hF); push("gen4_wrap", 64'h0);
        step = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i == 1)  chk(64'(ack_t));
            if (i == 15) chk(64'(gen_g));
            if (i == 16) chk(64'(gen_g));
        end
        step = 1'b0;
        push("torus_grid", glider); push("torus_gen", 64'd32);
        push("edge_differs", 64'h1); push("gen4_32", 64'h0);
        read_grid(ga, gt);
        chk(gt); chk(64'(gen_t)); chk(64'(ga !== glider)); chk(64'(gen_g));

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_leftover: observed=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
